frame_buf_bist: RTL and testbench
=================================

Name: frame_buf_bist

Overview:
Parametrised built-in self-test engine for the external frame-buffer RAM port. It writes a selectable data pattern over a configurable address window through the Avalon-style request/ready handshake, reads the window back, and checks every returned word. It reports pass/fail, a saturating error count and the first failing index. It attaches to one port of the multi-port RAM interface in place of the frame buffer controller during bring-up, clocked by the pixel clock domain.

Parameters:
DATA_W, 32, RAM data word width
ADDR_W, 29, RAM word address width
NUM_WORDS, 307200, words per test pass (640x480 frame); minimum 1
BASE_ADDR, 0, first word address of the window
ADDR_STRIDE, 1, address increment per word
PATT, 32'h00FFFFFF, base data pattern (low DATA_W bits used)
CMP_MASK, 32'h00FFFFFF, compare mask; only bits set to 1 are checked
TIMEOUT, 1024, maximum cycles without a new rd_data_valid while reads are outstanding
ERR_CNT_W, 16, width of the error counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse that launches a test
mode  in  2  pattern select, sampled on start
ram_rdy  in  1  RAM calibration/initialisation complete
avl_ready  in  1  RAM port accepts a request this cycle
avl_write_req  out  1  write request
avl_read_req  out  1  read request
avl_addr  out  ADDR_W  request address
wr_data  out  DATA_W  write data
rd_data  in  DATA_W  read return data
rd_data_valid  in  1  rd_data valid this cycle
busy  out  1  test in progress
pass  out  1  test completed, no errors
fail  out  1  test completed with errors or timeout
err_cnt  out  ERR_CNT_W  mismatch count, saturating
first_err_idx  out  32  index of the first mismatching word

Behaviour:
- Reset: state IDLE. All outputs are 0; the internal counters are 0.
- Pattern for index i, by latched mode:
  - 0: PATT.
  - 1: i, zero-extended or truncated to DATA_W.
  - 2: ~i.
  - 3: PATT for even i, ~PATT for odd i.
- Address for index i: BASE_ADDR + i*ADDR_STRIDE, modulo 2^ADDR_W (wraps silently).
- Handshake: a request is accepted on a cycle where req && avl_ready. avl_addr, wr_data and req are held stable until acceptance. At most one request is asserted per cycle. Write and read requests are never asserted together.
- IDLE:
  - On start, latch mode, clear pass, fail, err_cnt and first_err_idx, set busy=1, go to WAIT_RDY.
  - start while busy=1 is ignored.
- WAIT_RDY: when ram_rdy=1, go to WRITE at wr_idx=0.
- WRITE:
  - avl_write_req=1 with pattern(wr_idx).
  - On acceptance, wr_idx++.
  - After acceptance of index NUM_WORDS-1, go to READ at rd_idx=0 on the next cycle.
- READ:
  - avl_read_req=1 with addr(rd_idx).
  - On acceptance, rd_idx++.
  - After the last acceptance, go to DRAIN.
  - Return checking runs concurrently in READ and DRAIN.
- Check, on each rd_data_valid:
  - Compare (rd_data ^ pattern(chk_idx)) & CMP_MASK against 0, then chk_idx++.
  - On a mismatch, increment err_cnt, saturating at all-ones.
  - On the first mismatch only, capture chk_idx into first_err_idx.
  - Comparison is combinational on the valid cycle. err_cnt updates one cycle after the valid.
- DRAIN:
  - When chk_idx reaches NUM_WORDS, go to DONE.
  - A watchdog counts cycles since the last rd_data_valid, or since entering READ. It resets on each valid.
  - If the watchdog reaches TIMEOUT in READ or DRAIN, go to DONE with fail forced.
- DONE:
  - busy=0. pass=1 iff err_cnt==0 and no timeout, else fail=1. pass and fail are mutually exclusive and held.
  - A new start restarts the test: clear the results and go to WAIT_RDY.
- rd_data_valid outside READ/DRAIN, or beyond NUM_WORDS returns, sets a sticky overrun flag that forces fail in DONE. An overrun seen in DONE sets fail=1 and clears pass.
- ram_rdy falling mid-test: outstanding requests stay asserted (stalled by avl_ready). No abort.
- Reset mid-operation: the next cycle is IDLE with requests deasserted. Returns still in flight afterwards are ignored while in IDLE.
- Total latency, fault-free with avl_ready held at 1: about 2*NUM_WORDS + read latency + 3 cycles.

Test Plan:
- NUM_WORDS=16, mode=0, ideal RAM model (1-cycle ready, 3-cycle read latency), start pulse -> 16 writes of 32'h00FFFFFF to addr 0..15, 16 reads; pass=1, fail=0, err_cnt=0, busy falls.
- mode=1, ADDR_STRIDE=4, BASE_ADDR=100 -> writes data 0..15 at addr 100,104..160; avl_ready toggled randomly, data and address held stable while stalled; pass=1.
- mode=3, model flips bit 3 of returned words 5 and 9 -> fail=1, err_cnt=2, first_err_idx=5. Flipping bit 31 instead (masked out) -> pass=1.
- Model drops the last read return -> fail=1 exactly TIMEOUT cycles after the 15th valid; busy=0.
- ram_rdy held 0 for 50 cycles after start -> no requests and busy=1 throughout; then normal completion with pass=1. Extra rd_data_valid in DONE -> fail=1, pass=0.
- Reset asserted mid-READ -> next cycle avl_read_req=0, busy=0, pass=fail=0. A new start then completes a full test with pass=1.

Source files
------------

// File: rtl/frame_buf_bist.sv
// Frame-buffer RAM self-test: writes a pattern over an address window, reads it back,
// and reports pass/fail, a saturating mismatch count and the first failing index.
//
// state    | meaning
// IDLE     | waiting for start
// WAIT_RDY | waiting for RAM calibration
// WRITE    | issuing write requests
// READ     | issuing read requests, checking returns
// DRAIN    | all reads issued, checking remaining returns
// DONE     | result held until the next start
module frame_buf_bist #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned NUM_WORDS   = 307200,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STRIDE = 1,
  parameter logic [31:0] PATT        = 32'h00FFFFFF,
  parameter logic [31:0] CMP_MASK    = 32'h00FFFFFF,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 ram_rdy,
  input  logic                 avl_ready,
  output logic                 avl_write_req,
  output logic                 avl_read_req,
  output logic [ADDR_W-1:0]    avl_addr,
  output logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W-1:0]    rd_data,
  input  logic                 rd_data_valid,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          first_err_idx
);

  localparam logic [31:0]        LAST_IDX = 32'(NUM_WORDS - 1);
  localparam logic [31:0]        N_WORDS  = 32'(NUM_WORDS);
  localparam int unsigned        WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]    WD_LOAD  = WD_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0]  PATT_D   = DATA_W'(PATT);
  localparam logic [DATA_W-1:0]  MASK_D   = DATA_W'(CMP_MASK);
  localparam logic [ADDR_W-1:0]  BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  STRIDE_A = ADDR_W'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, WRITE, READ, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]           mode_q;
  logic [31:0]          wr_idx, rd_idx, chk_idx;
  logic [ADDR_W-1:0]    addr_q;
  logic [WD_W-1:0]      wd_cnt;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [31:0]          first_err_q;
  logic                 timeout_q, overrun_q;

  logic launch, wr_acc, rd_acc, checking, chk_live, mismatch, wd_expired, overrun_hit, done_ok;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [31:0] i);
    logic [DATA_W-1:0] iv;
    iv = DATA_W'(i);
    case (m)
      2'd0:    pattern = PATT_D;
      2'd1:    pattern = iv;
      2'd2:    pattern = ~iv;
      default: pattern = i[0] ? ~PATT_D : PATT_D;
    endcase
  endfunction

  assign launch      = start && (state == IDLE || state == DONE);
  assign wr_acc      = (state == WRITE) && avl_ready;
  assign rd_acc      = (state == READ) && avl_ready;
  assign checking    = (state == READ) || (state == DRAIN);
  assign chk_live    = checking && rd_data_valid && (chk_idx < N_WORDS);
  assign mismatch    = |((rd_data ^ pattern(mode_q, chk_idx)) & MASK_D);
  assign wd_expired  = checking && !rd_data_valid && (wd_cnt == '0);
  // Returns in IDLE are leftovers from an aborted run and are ignored.
  assign overrun_hit = rd_data_valid &&
                       ((state == WAIT_RDY) || (state == WRITE) || (state == DONE) ||
                        (checking && chk_idx >= N_WORDS));
  assign done_ok     = !timeout_q && !overrun_q && (err_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    avl_write_req = 1'b0;
    avl_read_req  = 1'b0;
    avl_addr      = '0;
    wr_data       = '0;
    busy          = 1'b0;
    pass          = 1'b0;
    fail          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        busy = 1'b1;
        if (ram_rdy) state_nxt = WRITE;
      end
      WRITE: begin
        busy          = 1'b1;
        avl_write_req = 1'b1;
        avl_addr      = addr_q;
        wr_data       = pattern(mode_q, wr_idx);
        if (avl_ready && wr_idx == LAST_IDX) state_nxt = READ;
      end
      READ: begin
        busy         = 1'b1;
        avl_read_req = 1'b1;
        avl_addr     = addr_q;
        if (wd_expired)                           state_nxt = DONE;
        else if (avl_ready && rd_idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (chk_idx == N_WORDS || wd_expired) state_nxt = DONE;
      end
      DONE: begin
        pass = done_ok;
        fail = !done_ok;
        if (start) state_nxt = WAIT_RDY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      chk_idx     <= '0;
      addr_q      <= '0;
      wd_cnt      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (launch) begin
        mode_q      <= mode;
        wr_idx      <= '0;
        rd_idx      <= '0;
        chk_idx     <= '0;
        addr_q      <= BASE_A;
        err_cnt_q   <= '0;
        first_err_q <= '0;
        timeout_q   <= 1'b0;
      end
      if (wr_acc) begin
        wr_idx <= wr_idx + 32'd1;
        if (wr_idx == LAST_IDX) begin
          addr_q <= BASE_A;
          wd_cnt <= WD_LOAD;
        end else begin
          addr_q <= addr_q + STRIDE_A;
        end
      end
      if (rd_acc) begin
        rd_idx <= rd_idx + 32'd1;
        addr_q <= addr_q + STRIDE_A;
      end
      if (chk_live) begin
        chk_idx <= chk_idx + 32'd1;
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
          if (err_cnt_q == '0) first_err_q <= chk_idx;
        end
      end
      // Watchdog: down-counter reloaded by every return while checking.
      if (checking) begin
        if (rd_data_valid)        wd_cnt <= WD_LOAD;
        else if (wd_cnt != '0)    wd_cnt <= wd_cnt - WD_W'(1);
      end
      if (wd_expired) timeout_q <= 1'b1;
      if (launch)           overrun_q <= 1'b0;
      else if (overrun_hit) overrun_q <= 1'b1;
    end
  end

  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_frame_buf_bist.sv
// Directed bench for frame_buf_bist: behavioural RAM with 3-cycle read latency,
// optional random ready, bit-flip and dropped-return fault injection.
module tb_frame_buf_bist;
  localparam int NW     = 16;
  localparam int BASE   = 100;
  localparam int STRIDE = 4;
  localparam int TO     = 32;
  localparam logic [31:0] PATT = 32'h00FFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        ram_rdy = 1'b0;
  logic        avl_ready;
  logic        avl_write_req, avl_read_req;
  logic [28:0] avl_addr;
  logic [31:0] wr_data, rd_data;
  logic        rd_data_valid;
  logic        busy, pass, fail;
  logic [15:0] err_cnt;
  logic [31:0] first_err_idx;

  int checks = 0;
  int errors = 0;
  int pcyc = 0;

  frame_buf_bist #(
    .DATA_W(32), .ADDR_W(29), .NUM_WORDS(NW), .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE),
    .PATT(PATT), .CMP_MASK(32'h00FFFFFF), .TIMEOUT(TO), .ERR_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ram_rdy(ram_rdy),
    .avl_ready(avl_ready), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_addr(avl_addr), .wr_data(wr_data), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .busy(busy), .pass(pass), .fail(fail), .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  // RAM model configuration and bookkeeping
  int          exp_mode = 0;
  bit          rand_ready = 1'b0;
  int          flip_a = -1, flip_b = -1;
  logic [31:0] flip_mask = '0;
  bit          drop_last = 1'b0;
  bit          extra_valid = 1'b0;
  int          wr_n = 0, rd_n = 0;
  int          ret14_p = 0;

  typedef struct { int due; int idx; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  logic [31:0] mem [int];

  function automatic logic [31:0] exp_pat(input int m, input int i);
    case (m)
      0:       return PATT;
      1:       return 32'(i);
      2:       return ~32'(i);
      default: return (i % 2 == 1) ? ~PATT : PATT;
    endcase
  endfunction

  initial begin
    ret_t        r;
    logic [31:0] d;
    bit          stalled = 1'b0, s_wr = 1'b0;
    logic [28:0] s_addr = '0;
    logic [31:0] s_data = '0;
    avl_ready = 1'b0;
    rd_data = '0;
    rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      rd_data_valid = 1'b0;
      rd_data = '0;
      if (rq.size() > 0 && rq[0].due <= pcyc) begin
        r = rq.pop_front();
        if (!(drop_last && r.idx == NW - 1)) begin
          rd_data_valid = 1'b1;
          rd_data = r.data;
        end
        if (r.idx == NW - 2) ret14_p = pcyc;
      end
      if (extra_valid) begin
        rd_data_valid = 1'b1;
        rd_data = 32'hDEADBEEF;
        extra_valid = 1'b0;
      end
      if (stalled) begin
        checks++;
        if ((s_wr ? !avl_write_req : !avl_read_req) || avl_addr !== s_addr ||
            (s_wr && wr_data !== s_data)) begin
          errors++;
          $display("FAIL stall_hold: addr=%0d data=%h wr=%b rd=%b, required addr=%0d data=%h held",
                   avl_addr, wr_data, avl_write_req, avl_read_req, s_addr, s_data);
        end
      end
      if (avl_write_req || avl_read_req) begin
        checks++;
        if (avl_write_req && avl_read_req) begin
          errors++;
          $display("FAIL one_req: write_req=1 read_req=1, required at most one");
        end
      end
      avl_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = (avl_write_req || avl_read_req) && !avl_ready;
      s_wr = avl_write_req;
      s_addr = avl_addr;
      s_data = wr_data;
      if (avl_write_req && avl_ready) begin
        checks++;
        if (avl_addr !== 29'(BASE + STRIDE * wr_n) || wr_data !== exp_pat(exp_mode, wr_n)) begin
          errors++;
          $display("FAIL write_%0d: addr=%0d data=%h, required addr=%0d data=%h", wr_n,
                   avl_addr, wr_data, BASE + STRIDE * wr_n, exp_pat(exp_mode, wr_n));
        end
        mem[int'(avl_addr)] = wr_data;
        wr_n++;
      end
      if (avl_read_req && avl_ready) begin
        checks++;
        if (avl_addr !== 29'(BASE + STRIDE * rd_n)) begin
          errors++;
          $display("FAIL read_addr_%0d: addr=%0d, required %0d", rd_n, avl_addr, BASE + STRIDE * rd_n);
        end
        d = mem.exists(int'(avl_addr)) ? mem[int'(avl_addr)] : '0;
        if (rd_n == flip_a || rd_n == flip_b) d = d ^ flip_mask;
        rq.push_back('{pcyc + 3, rd_n, d});
        rd_n++;
      end
    end
  end

  task automatic setup(input int m, input bit rr, input int fa, input int fb,
                       input logic [31:0] fm, input bit drop);
    exp_mode = m; rand_ready = rr; flip_a = fa; flip_b = fb; flip_mask = fm; drop_last = drop;
    wr_n = 0; rd_n = 0;
  endtask

  task automatic pulse_start(input logic [1:0] m, output int sp);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    sp = pcyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int dp);
    int n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    dp = pcyc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, pass, fail, avl_write_req, avl_read_req} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: busy,pass,fail,wr,rd=%b, required 00000",
               {busy, pass, fail, avl_write_req, avl_read_req});
    end
    checks++;
    if (err_cnt !== 16'd0 || first_err_idx !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts: err_cnt=%0d first=%0d, required 0 0", err_cnt, first_err_idx);
    end
    checks++;
    if (avl_addr !== 29'd0 || wr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d data=%h, required 0 0", avl_addr, wr_data);
    end
    reset = 1'b0;
    ram_rdy = 1'b1;
  endtask

  task automatic test_mode0;
    int sp, dp;
    setup(0, 1'b0, -1, -1, '0, 1'b0);
    pulse_start(2'd0, sp);
    wait_idle(500, dp);
    checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || fail !== 1'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mode0_result: busy=%b pass=%b fail=%b err=%0d, required 0 1 0 0", busy, pass, fail, err_cnt);
    end
    checks++;
    if (wr_n != NW || rd_n != NW) begin
      errors++;
      $display("FAIL mode0_counts: writes=%0d reads=%0d, required %0d %0d", wr_n, rd_n, NW, NW);
    end
    checks++;
    if (dp - sp != 2 * NW + 6) begin
      errors++;
      $display("FAIL mode0_latency: %0d cycles, required %0d", dp - sp, 2 * NW + 6);
    end
  endtask

  task automatic test_stride_stall;
    int sp, dp;
    setup(1, 1'b1, -1, -1, '0, 1'b0);
    pulse_start(2'd1, sp);
    wait_idle(1000, dp);
    rand_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL stall_result: busy=%b pass=%b fail=%b, required 0 1 0", busy, pass, fail);
    end
    checks++;
    if (wr_n != NW || rd_n != NW) begin
      errors++;
      $display("FAIL stall_counts: writes=%0d reads=%0d, required %0d %0d", wr_n, rd_n, NW, NW);
    end
  endtask

  task automatic test_mismatch;
    int sp, dp;
    setup(3, 1'b0, 5, 9, 32'h0000_0008, 1'b0);
    pulse_start(2'd3, sp);
    wait_idle(500, dp);
    checks++;
    if (pass !== 1'b0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL mm_flags: pass=%b fail=%b, required 0 1", pass, fail);
    end
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL mm_err_cnt: %0d, required 2", err_cnt);
    end
    checks++;
    if (first_err_idx !== 32'd5) begin
      errors++;
      $display("FAIL mm_first_idx: %0d, required 5", first_err_idx);
    end
    setup(3, 1'b0, 5, 9, 32'h8000_0000, 1'b0);
    pulse_start(2'd3, sp);
    wait_idle(500, dp);
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || err_cnt !== 16'd0 || first_err_idx !== 32'd0) begin
      errors++;
      $display("FAIL mm_masked: pass=%b fail=%b err=%0d first=%0d, required 1 0 0 0",
               pass, fail, err_cnt, first_err_idx);
    end
  endtask

  task automatic test_timeout;
    int sp, fp, n;
    setup(2, 1'b0, -1, -1, '0, 1'b1);
    pulse_start(2'd2, sp);
    n = 0;
    while (fail !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    fp = pcyc;
    drop_last = 1'b0;
    checks++;
    if (fail !== 1'b1 || fp - ret14_p != TO + 1) begin
      errors++;
      $display("FAIL timeout_time: fail=%b after %0d cycles, required fail=1 after %0d", fail,
               fp - ret14_p - 1, TO);
    end
    checks++;
    if (busy !== 1'b0 || pass !== 1'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL timeout_state: busy=%b pass=%b err=%0d, required 0 0 0", busy, pass, err_cnt);
    end
  endtask

  task automatic test_ram_rdy;
    int sp, dp;
    bit bad = 1'b0;
    ram_rdy = 1'b0;
    setup(0, 1'b0, -1, -1, '0, 1'b0);
    pulse_start(2'd0, sp);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin mode = 2'd2; start = 1'b1; end
      if (i == 21) start = 1'b0;
      checks++;
      if (avl_write_req !== 1'b0 || avl_read_req !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rdy_hold_%0d: wr=%b rd=%b busy=%b, required 0 0 1", i, avl_write_req, avl_read_req, busy);
      end
      @(negedge clk);
    end
    ram_rdy = 1'b1;
    wait_idle(500, dp);
    checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || fail !== 1'b0 || wr_n != NW) begin
      errors++;
      $display("FAIL rdy_result: busy=%b pass=%b fail=%b writes=%0d, required 0 1 0 %0d",
               busy, pass, fail, wr_n, NW);
    end
    extra_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pass !== 1'b0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL overrun: pass=%b fail=%b, required 0 1", pass, fail);
    end
    if (bad) errors++;
  endtask

  task automatic test_reset_mid_read;
    int sp, dp, n;
    setup(1, 1'b0, -1, -1, '0, 1'b0);
    pulse_start(2'd1, sp);
    n = 0;
    while (rd_n < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (avl_read_req !== 1'b0 || busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || rd_n < 4) begin
      errors++;
      $display("FAIL midreset: rd=%b busy=%b pass=%b fail=%b reads=%0d, required 0 0 0 0 >=4",
               avl_read_req, busy, pass, fail, rd_n);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    setup(2, 1'b0, -1, -1, '0, 1'b0);
    pulse_start(2'd2, sp);
    wait_idle(500, dp);
    checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || fail !== 1'b0 || rd_n != NW) begin
      errors++;
      $display("FAIL after_reset: busy=%b pass=%b fail=%b reads=%0d, required 0 1 0 %0d",
               busy, pass, fail, rd_n, NW);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_stride_stall();
    test_mismatch();
    test_timeout();
    test_ram_rdy();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench time limit");
  end
endmodule
